// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared state encoding and parameter defaults for the memory port arbiter
package mem_arb_pkg;
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    IFETCH  = 2'd1,
    DACCESS = 2'd2
  } state_e;
  localparam int TIMEOUT_CYC_DEF  = 255;
  localparam int MAX_DATA_RUN_DEF = 4;
endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: fetch, data and memory-side handshake bundle for the arbiter
interface mem_port_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_valid;
  logic [31:0] if_rdata;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_valid;
  logic [31:0] d_rdata;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        busy;
  logic        err;
  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_ack, mem_rdata,
    output if_valid, if_rdata, d_valid, d_rdata, mem_req, mem_we, mem_addr, mem_wdata, busy, err
  );
  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_ack, mem_rdata,
    input  if_valid, if_rdata, d_valid, d_rdata, mem_req, mem_we, mem_addr, mem_wdata, busy, err
  );
endinterface

// File: rtl/mem_arb_timer.sv
// mem_arb_timer: access-cycle counter that flags the cycle in which the access runs out of time
module mem_arb_timer
  import mem_arb_pkg::*;
#(
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  logic [7:0] cnt_q, cnt_d;
  assign cnt_d   = clear ? 8'd0 : enable ? cnt_q + 8'd1 : cnt_q;
  assign expired = enable && cnt_q == 8'(TIMEOUT_CYC - 1);
  // count unacknowledged access cycles; expired marks the edge where the count reaches the limit
  always_ff @(posedge clk) begin
    if (reset) cnt_q <= 8'd0;
    else cnt_q <= cnt_d;
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between a fetch and a data requester with run limiting and timeout
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int TIMEOUT_CYC  = TIMEOUT_CYC_DEF,
  parameter int MAX_DATA_RUN = MAX_DATA_RUN_DEF
) (
  input logic               clk,
  input logic               reset,
  mem_port_arbiter_if.slave bus
);
  localparam logic [3:0] RUN_MAX = 4'(MAX_DATA_RUN);
  state_e      state_q;
  logic [3:0]  run_q;
  logic        if_valid_q, d_valid_q, err_q, mem_req_q, mem_we_q;
  logic [31:0] if_rdata_q, d_rdata_q, mem_addr_q, mem_wdata_q;
  logic        d_win, f_win, grant_d, grant_f, in_acc, expired;
  assign in_acc  = state_q != IDLE;
  assign d_win   = bus.d_req && !(bus.if_req && run_q == RUN_MAX);
  assign f_win   = bus.if_req && !d_win;
  assign grant_d = !in_acc && d_win && !d_valid_q;
  assign grant_f = !in_acc && f_win && !if_valid_q;
  mem_arb_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (grant_d || grant_f),
    .enable  (in_acc && !bus.mem_ack),
    .expired (expired)
  );
  // grant in IDLE, hold the memory request, then retire it with a one-cycle valid (and err on timeout)
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      run_q       <= 4'd0;
      if_valid_q  <= 1'b0;
      d_valid_q   <= 1'b0;
      err_q       <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      if_valid_q <= 1'b0;
      d_valid_q  <= 1'b0;
      err_q      <= 1'b0;
      if (grant_d || grant_f) begin
        state_q     <= grant_d ? DACCESS : IFETCH;
        mem_req_q   <= 1'b1;
        mem_we_q    <= grant_d && bus.d_we;
        mem_addr_q  <= grant_d ? bus.d_addr : bus.if_addr;
        mem_wdata_q <= grant_d ? bus.d_wdata : '0;
        run_q       <= grant_f ? 4'd0 : (bus.if_req && run_q != RUN_MAX) ? run_q + 4'd1 : run_q;
      end else if (in_acc && (bus.mem_ack || expired)) begin
        state_q   <= IDLE;
        mem_req_q <= 1'b0;
        err_q     <= !bus.mem_ack;
        if (state_q == IFETCH) begin
          if_valid_q <= 1'b1;
          if_rdata_q <= bus.mem_ack ? bus.mem_rdata : '0;
        end else begin
          d_valid_q <= 1'b1;
          d_rdata_q <= (bus.mem_ack && !mem_we_q) ? bus.mem_rdata : '0;
        end
      end
    end
  end
  assign bus.if_valid  = if_valid_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.d_valid   = d_valid_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.busy      = in_acc;
  assign bus.err       = err_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scoreboard bench for the memory port arbiter
module tb_mem_port_arbiter;
  typedef struct {
    logic        is_d;
    logic        err;
    logic [31:0] rdata;
  } exp_t;
  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n;
  exp_t sb[$];
  bit   go[$];
  mem_port_arbiter_if bus();
  mem_port_arbiter #(.TIMEOUT_CYC(8), .MAX_DATA_RUN(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic push(input logic is_d, input logic err, input logic [31:0] rdata);
    exp_t e;
    e.is_d  = is_d;
    e.err   = err;
    e.rdata = rdata;
    sb.push_back(e);
  endtask
  task automatic ack(input logic [31:0] data);
    bus.mem_rdata = data;
    bus.mem_ack   = 1'b1;
    step();
    bus.mem_ack   = 1'b0;
  endtask
  task automatic expect_done(input string tag, input int max_cyc);
    exp_t e;
    int   k = 0;
    while (!(bus.if_valid || bus.d_valid) && k < max_cyc) begin
      step();
      k++;
    end
    e = sb.pop_front();
    chk({tag, "_valid"}, {bus.d_valid, bus.if_valid}, e.is_d ? 2'b10 : 2'b01);
    chk({tag, "_err"}, bus.err, e.err);
    chk({tag, "_rdata"}, e.is_d ? bus.d_rdata : bus.if_rdata, e.rdata);
  endtask
  initial begin
    reset = 1'b1;
    bus.if_req = 0; bus.if_addr = 0; bus.d_req = 0; bus.d_we = 0;
    bus.d_addr = 0; bus.d_wdata = 0; bus.mem_ack = 0; bus.mem_rdata = 0;
    step();
    step();
    reset = 1'b0;
    chk("rst_outs", {bus.busy, bus.mem_req, bus.if_valid, bus.d_valid, bus.err, bus.mem_we}, 6'd0);
    chk("rst_addr", bus.mem_addr, 32'h0);
    // fetch with ack in the first mem_req cycle
    bus.if_req = 1; bus.if_addr = 32'h10;
    step();
    chk("if_req_on", {bus.mem_req, bus.busy, bus.mem_we}, 3'b110);
    chk("if_addr", bus.mem_addr, 32'h10);
    chk("if_wdata", bus.mem_wdata, 32'h0);
    push(1'b0, 1'b0, 32'h0051_3093);
    ack(32'h0051_3093);
    expect_done("fetch", 0);
    step();
    chk("no_double", bus.mem_req, 1'b0);
    bus.if_req = 0;
    // store
    bus.d_req = 1; bus.d_we = 1; bus.d_addr = 32'h100; bus.d_wdata = 32'hDEAD_BEEF;
    step();
    chk("st_ctl", {bus.mem_req, bus.mem_we}, 2'b11);
    chk("st_addr", bus.mem_addr, 32'h100);
    chk("st_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
    push(1'b1, 1'b0, 32'h0);
    ack(32'h1234_5678);
    expect_done("store", 0);
    bus.d_req = 0;
    chk("if_hold", bus.if_rdata, 32'h0051_3093);
    // load acked after three request cycles
    bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h200;
    step();
    step();
    step();
    chk("ld_hold", {bus.mem_req, bus.mem_we, bus.mem_addr}, {2'b10, 32'h200});
    push(1'b1, 1'b0, 32'hCAFE_F00D);
    ack(32'hCAFE_F00D);
    expect_done("load", 0);
    bus.d_req = 0;
    step();
    step();
    chk("d_hold", bus.d_rdata, 32'hCAFE_F00D);
    // both requesters held: data run limited to four
    go = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
    bus.if_addr = 32'h40; bus.d_addr = 32'h80; bus.d_we = 0;
    bus.if_req = 1; bus.d_req = 1;
    for (int i = 0; i < 120 && go.size() > 0; i++) begin
      step();
      bus.mem_ack = 0;
      if (bus.mem_req) begin
        chk($sformatf("order%0d", 10 - go.size()), bus.mem_addr == 32'h80, go.pop_front());
        bus.mem_ack = 1;
        bus.mem_rdata = 32'h0;
      end
    end
    chk("order_count", go.size(), 0);
    bus.if_req = 0; bus.d_req = 0;
    step();
    bus.mem_ack = 0;
    step();
    // timeout with no ack
    bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h300;
    step();
    n = 0;
    while (bus.mem_req && n < 50) begin
      n++;
      step();
    end
    chk("to_len", n, 8);
    push(1'b1, 1'b1, 32'h0);
    expect_done("timeout", 0);
    chk("to_idle", {bus.mem_req, bus.busy}, 2'b00);
    bus.d_req = 0;
    step();
    ack(32'h77);
    chk("idle_ack", {bus.if_valid, bus.d_valid, bus.err, bus.busy}, 4'd0);
    step();
    chk("idle_ack2", {bus.if_valid, bus.d_valid, bus.err, bus.mem_req}, 4'd0);
    // ack coinciding with the timeout cycle
    bus.d_req = 1; bus.d_addr = 32'h400;
    step();
    for (int i = 0; i < 7; i++) step();
    chk("late_req", {bus.mem_req, bus.mem_addr}, {1'b1, 32'h400});
    push(1'b1, 1'b0, 32'h0BAD_C0DE);
    ack(32'h0BAD_C0DE);
    expect_done("edge_ack", 0);
    bus.d_req = 0;
    step();
    // reset during a fetch
    bus.if_req = 1; bus.if_addr = 32'h500;
    step();
    step();
    step();
    chk("pre_rst", bus.mem_req, 1'b1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("mid_rst", {bus.mem_req, bus.busy, bus.if_valid, bus.err}, 4'd0);
    chk("mid_rst_rdata", bus.if_rdata, 32'h0);
    step();
    chk("post_rst_req", {bus.mem_req, bus.mem_addr}, {1'b1, 32'h500});
    push(1'b0, 1'b0, 32'h1111_2222);
    ack(32'h1111_2222);
    expect_done("post_rst", 0);
    bus.if_req = 0;
    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 255: access cycles without mem_ack before abort; legal range 1..255.
REQ-002 SHALL have parameter MAX_DATA_RUN, default 4: consecutive data grants allowed while a fetch is pending; legal range 1..15.
REQ-003 SHALL have ports, one per line (name, direction, width, meaning):
  clk  in  1  single clock, rising edge
  reset  in  1  synchronous, active-high
  if_req  in  1  fetch request, level, held until if_valid
  if_addr  in  32  fetch address, stable while if_req high
  if_valid  out  1  one-cycle fetch completion pulse
  if_rdata  out  32  fetch data, valid with if_valid
  d_req  in  1  data request, level, held until d_valid
  d_we  in  1  1 = store, 0 = load
  d_addr  in  32  data address
  d_wdata  in  32  store data
  d_valid  out  1  one-cycle data completion pulse
  d_rdata  out  32  load data, valid with d_valid
  mem_req  out  1  memory access strobe
  mem_we  out  1  memory write enable
  mem_addr  out  32  memory address
  mem_wdata  out  32  memory write data
  mem_ack  in  1  memory completion, one cycle
  mem_rdata  in  32  memory read data, valid with mem_ack
  busy  out  1  high in any non-IDLE state
  err  out  1  one-cycle pulse with the valid of an aborted access

Function
REQ-004 SHALL implement FSM states IDLE, IFETCH, DACCESS; one outstanding memory access at most.
REQ-005 In IDLE, SHALL grant on the clock edge: d_req only -> DACCESS; if_req only -> IFETCH; neither -> stay in IDLE.
REQ-006 If d_req and if_req are both high in IDLE, SHALL grant data unless the data-run count equals MAX_DATA_RUN, in which case SHALL grant fetch.
REQ-007 Data-run count SHALL increment on each data grant made while if_req is high, saturate at MAX_DATA_RUN, and clear on any fetch grant.
REQ-008 On grant, SHALL register mem_addr/mem_we/mem_wdata from the winner and assert mem_req starting the cycle after the IDLE request cycle.
REQ-009 For a fetch, mem_we and mem_wdata SHALL be 0.
REQ-010 mem_req and all mem_* outputs SHALL stay constant until mem_ack or abort.
REQ-011 On mem_ack sampled in cycle M, SHALL in M+1: drive the winner's valid high for one cycle, drive its rdata from the mem_rdata captured in M, deassert mem_req, and be in IDLE.
REQ-012 For a store completion, d_rdata SHALL be 0.
REQ-013 A requester whose valid is high in the current cycle SHALL be ineligible for grant in that cycle, so a held req is not double-served.
REQ-014 Minimum request-to-valid latency SHALL be 2 cycles (ack in the first mem_req cycle); back-to-back accesses from one requester SHALL be spaced at least 3 cycles apart.
REQ-015 An access-cycle counter SHALL clear on grant and increment each IFETCH/DACCESS cycle without mem_ack.
REQ-016 When the access-cycle counter reaches TIMEOUT_CYC, SHALL abort the access: next cycle mem_req=0, winner valid=1, err=1, rdata=0, state IDLE.
REQ-017 mem_ack sampled in IDLE SHALL be ignored.
REQ-018 mem_ack in the same cycle the counter reaches TIMEOUT_CYC SHALL be treated as a normal completion (err=0).
REQ-019 if_rdata/d_rdata SHALL hold their last values when the corresponding valid is low.

Reset
REQ-020 When reset is high at a clock edge, the next cycle SHALL have state IDLE, both counters 0, and all outputs 0, including from mid-access.
REQ-021 Any in-flight access SHALL be dropped on reset with no valid or err pulse.

Structure
REQ-022 FSM state encodings (IDLE=2'd0, IFETCH=2'd1, DACCESS=2'd2) and parameter defaults SHALL reside in the shared package mem_arb_pkg.
REQ-023 The access-cycle counter and timeout compare SHALL be a sub-module mem_arb_timer (inputs clk, reset, clear, enable; output expired).

Verification
REQ-024 if_req=1, if_addr=0x0000_0010, ack after 1 mem_req cycle with mem_rdata=0x0051_3093 -> if_valid at cycle 2, if_rdata=0x0051_3093, mem_we=0.
REQ-025 d_req=1, d_we=1, d_addr=0x0000_0100, d_wdata=0xDEAD_BEEF -> mem_we=1, mem_addr=0x100, mem_wdata=0xDEADBEEF; d_valid with d_rdata=0.
REQ-026 if_req and d_req both held continuously, MAX_DATA_RUN=4 -> grant order D,D,D,D,I,D,D,D,D,I.
REQ-027 TIMEOUT_CYC=8, mem_ack never asserted -> mem_req high for exactly 8 cycles, then d_valid=1, err=1, d_rdata=0; a later mem_ack in IDLE produces no pulse.
REQ-028 reset asserted on the 3rd mem_req cycle of a fetch -> next cycle mem_req=0, busy=0, no if_valid; a new fetch afterwards completes normally.
REQ-029 mem_ack coinciding with the timeout cycle -> valid=1, err=0, rdata=mem_rdata.
